ifmap_write_addr_gen: RTL and testbench

IFMAP_WRITE_ADDR_GEN -- requirements
Module: ifmap_write_addr_gen

---
 rtl/ifmap_pkg.sv | 12 +
 rtl/ifmap_wrap_counter.sv | 30 +++
 rtl/ifmap_write_addr_gen.sv | 114 +++++++++++
 tb/tb_ifmap_write_addr_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ifmap_pkg.sv
// Shared types and default widths for the ifmap write address generator.
package ifmap_pkg;
  localparam int IFMAP_ADDR_W = 4;
  localparam int IFMAP_BANK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2,
    ST_DONE  = 2'd3
  } ifmap_state_e;
endpackage

// File: rtl/ifmap_wrap_counter.sv
// Up-counter that wraps to zero after reaching a run-time limit.
// wrap is combinational: high in the cycle the count at the limit is consumed.
module ifmap_wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap  = en && (cnt_q == limit);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ifmap_write_addr_gen.sv
// Write-side address generator for the ifmap double buffer.
// Optional: define IFMAP_WADDR_OVERFLOW_CHECK_EN to build the overflow_err detector.
module ifmap_write_addr_gen
  import ifmap_pkg::*;
#(
  parameter int ADDR_WIDTH     = IFMAP_ADDR_W,
  parameter int BANK_CNT_WIDTH = IFMAP_BANK_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      config_en,
  input  logic [ADDR_WIDTH-1:0]     config_last_addr,
  input  logic [BANK_CNT_WIDTH-1:0] config_last_bank,
  input  logic                      data_valid,
  input  logic                      switch,
  output logic                      wen,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic                      writing_last_data,
  output logic                      start_new_write_bank,
  output logic                      layer_done,
  output logic                      overflow_err
);
  ifmap_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]     last_addr_q, last_addr_d;
  logic [BANK_CNT_WIDTH-1:0] last_bank_q, last_bank_d;
  logic [BANK_CNT_WIDTH-1:0] bank_q, bank_d;
  logic                      snwb_q, snwb_d;
  logic                      new_bank;
  logic                      addr_en, addr_wrap;

  assign addr_en = (state_q == ST_WRITE) && data_valid;

  ifmap_wrap_counter #(.WIDTH(ADDR_WIDTH)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (addr_en),
    .clr   (config_en),
    .limit (last_addr_q),
    .count (waddr),
    .wrap  (addr_wrap)
  );

  assign wen                  = addr_en;
  assign writing_last_data    = addr_wrap;
  assign start_new_write_bank = snwb_q;
  assign layer_done           = (state_q == ST_DONE);

  always_comb begin
    state_d     = state_q;
    last_addr_d = last_addr_q;
    last_bank_d = last_bank_q;
    bank_d      = bank_q;
    new_bank    = 1'b0;
    // config_en restarts the layer from any state, including mid-bank
    if (config_en) begin
      state_d     = ST_WRITE;
      last_addr_d = config_last_addr;
      last_bank_d = config_last_bank;
      bank_d      = '0;
      new_bank    = 1'b1;
    end else begin
      case (state_q)
        ST_WRITE: if (addr_wrap) state_d = ST_FULL;
        ST_FULL: if (switch) begin
          if (bank_q == last_bank_q) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_WRITE;
            bank_d   = bank_q + BANK_CNT_WIDTH'(1);
            new_bank = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // back-to-back restarts collapse into a single pulse
    snwb_d = new_bank && !snwb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_addr_q <= '0;
      last_bank_q <= '0;
      bank_q      <= '0;
      snwb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_addr_q <= last_addr_d;
      last_bank_q <= last_bank_d;
      bank_q      <= bank_d;
      snwb_q      <= snwb_d;
    end
  end

`ifdef IFMAP_WADDR_OVERFLOW_CHECK_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (config_en)                             ovf_d = 1'b0;
    else if (data_valid && state_q != ST_WRITE) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_err = ovf_q;
`else
  assign overflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_ifmap_write_addr_gen.sv
// Randomized bench for ifmap_write_addr_gen against a flag-based layer model,
// plus directed scenarios with hand-computed expectations.
module tb_ifmap_write_addr_gen;
  localparam int AW = 4;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          config_en;
  logic [AW-1:0] config_last_addr;
  logic [BW-1:0] config_last_bank;
  logic          data_valid;
  logic          switch;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          writing_last_data;
  logic          start_new_write_bank;
  logic          layer_done;
  logic          overflow_err;

  int total = 0;
  int bad   = 0;

  ifmap_write_addr_gen dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .config_en            (config_en),
    .config_last_addr     (config_last_addr),
    .config_last_bank     (config_last_bank),
    .data_valid           (data_valid),
    .switch               (switch),
    .wen                  (wen),
    .waddr                (waddr),
    .writing_last_data    (writing_last_data),
    .start_new_write_bank (start_new_write_bank),
    .layer_done           (layer_done),
    .overflow_err         (overflow_err)
  );

  always #5 clk = ~clk;

`ifdef IFMAP_WADDR_OVERFLOW_CHECK_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Layer model: a bank is writable once configured, until it fills or the layer completes
  bit m_cfgd, m_full, m_done, m_snwb, m_ovf;
  int m_addr, m_bank, m_last_addr, m_last_bank;

  function automatic bit writable();
    return m_cfgd && !m_full && !m_done;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cfgd = 0; m_full = 0; m_done = 0; m_snwb = 0; m_ovf = 0;
      m_addr = 0; m_bank = 0; m_last_addr = 0; m_last_bank = 0;
    end else if (config_en) begin
      m_cfgd = 1; m_full = 0; m_done = 0; m_ovf = 0;
      m_addr = 0; m_bank = 0;
      m_last_addr = int'(config_last_addr);
      m_last_bank = int'(config_last_bank);
      m_snwb = !m_snwb;
    end else begin
      bit nb;
      nb = 0;
      if (data_valid && !writable()) m_ovf = OVF_ON;
      if (writable() && data_valid) begin
        if (m_addr == m_last_addr) begin m_addr = 0; m_full = 1; end
        else m_addr++;
      end else if (m_full && switch) begin
        m_full = 0;
        if (m_bank == m_last_bank) m_done = 1;
        else begin m_bank++; nb = !m_snwb; end
      end
      m_snwb = nb;
    end
  end

  always @(negedge clk) begin
    bit ew;
    ew = writable() && data_valid;
    chk("wen", int'(wen), int'(ew));
    chk("waddr", int'(waddr), m_addr);
    chk("writing_last_data", int'(writing_last_data), int'(ew && m_addr == m_last_addr));
    chk("start_new_write_bank", int'(start_new_write_bank), int'(m_snwb));
    chk("layer_done", int'(layer_done), int'(m_done));
    chk("overflow_err", int'(overflow_err), int'(m_ovf));
  end

  task automatic drive(input bit ce, input int la, input int lb, input bit dv, input bit sw);
    config_en        = ce;
    config_last_addr = AW'(la);
    config_last_bank = BW'(lb);
    data_valid       = dv;
    switch           = sw;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_wen"}, int'(wen), 0);
    chk({nm, "_waddr"}, int'(waddr), 0);
    chk({nm, "_wld"}, int'(writing_last_data), 0);
    chk({nm, "_snwb"}, int'(start_new_write_bank), 0);
    chk({nm, "_done"}, int'(layer_done), 0);
    chk({nm, "_ovf"}, int'(overflow_err), 0);
  endtask

  initial begin
    int exp_a [4] = '{0, 1, 1, 2};
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // 4-word banks, 2 banks
    drive(1, 3, 1, 0, 0); #1;
    chk("idle_wen", int'(wen), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0); #1;
      chk("s1_waddr", int'(waddr), i);
      chk("s1_wld", int'(writing_last_data), int'(i == 3));
      chk("s1_snwb", int'(start_new_write_bank), int'(i == 0));
      tick();
    end
    drive(0, 0, 0, 0, 1); #1;
    chk("full_wen", int'(wen), 0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    chk("bank2_snwb", int'(start_new_write_bank), 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0); tick();
    end
    drive(0, 0, 0, 0, 1); #1;
    chk("pre_done", int'(layer_done), 0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    chk("layer_done", int'(layer_done), 1);
    chk("done_snwb", int'(start_new_write_bank), 0);
    tick();

    // gapped valid
    drive(1, 3, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, (i % 2) == 0, 0); #1;
      chk("gap_waddr", int'(waddr), exp_a[i]);
      chk("gap_wen", int'(wen), int'((i % 2) == 0));
      tick();
    end

    // one-word banks, three banks
    drive(1, 0, 2, 0, 0); tick();
    for (int b = 0; b < 3; b++) begin
      drive(0, 0, 0, 1, 0); #1;
      chk("w1_wld", int'(writing_last_data), 1);
      tick();
      drive(0, 0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0, 0); #1;
    chk("w1_done", int'(layer_done), 1);
    tick();

    // write while full
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 0); #1;
    chk("full_dv_wen", int'(wen), 0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    chk("ovf", int'(overflow_err), int'(OVF_ON));
    tick();

    // reset mid-bank
    drive(1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0); tick(); tick(); #1;
    chk("pre_rst_waddr", int'(waddr), 2);
    rst_n = 1'b0; #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    drive(1, 5, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 0); #1;
    chk("post_rst_waddr", int'(waddr), 0);
    chk("post_rst_wen", int'(wen), 1);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 5), $urandom_range(0, 2),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25);
      rst_n = !($urandom_range(0, 999) < 4);
      tick();
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
